column_frame_buffer: RTL and testbench
======================================

// Module: column_frame_buffer
// PURPOSE
//  Double-buffered column store between the ray caster and the VGA scan-out. Accepts one
//  {column, line height, wall colour} result per handshake into the back bank. Swaps banks
//  at frame start once a full frame of columns is written. Turns the front bank plus the
//  live pixel position into registered 4-bit RGB: ceiling, wall, floor and muzzle-flash overlay.
// PARAMETERS
//  WIDTH   320  columns per frame (screen x extent)
//  HEIGHT  240  rows per frame (screen y extent); must be < 256
//  COL_W   9    width of column index
// PORTS
//  clk          in   1      system clock (100 MHz)
//  rst          in   1      reset, asynchronous, active-high
//  wr_valid     in   1      caster result available
//  wr_ready     out  1      block can accept a result this cycle
//  wr_col       in   COL_W  column index of result
//  wr_height    in   8      wall line height in pixels
//  wr_color     in   4      wall colour code
//  frame_start  in   1      1-cycle pulse at start of vertical blank
//  pix_x        in   10     current scan x
//  pix_y        in   9      current scan y
//  shot         in   1      weapon firing; enables muzzle-flash overlay
//  vga_r/g/b    out  4 ea   registered colour
//  swap_pending out  1      back bank complete, waiting for frame_start
//  frame_count  out  13     number of bank swaps, wraps at 8191
// BEHAVIOUR
//  Reset (async, immediate): vga_r/g/b=0, wr_ready=1, swap_pending=0, frame_count=0,
//   front_sel=0, shown_valid=0. RAM contents not reset.
//  Write side:
//   - transfer = wr_valid & wr_ready; wr_ready = ~swap_pending (combinational).
//   - h = min(wr_height, HEIGHT); top = (HEIGHT-h)>>1; bot = top+h (exclusive), 8-bit.
//   - entry {bot,top,color} (20 b) written to back bank [wr_col] on the transfer edge.
//   - wr_col >= WIDTH: accepted, discarded, no state change.
//   - transfer with wr_col == WIDTH-1: swap_pending=1 from the next cycle.
//   - column order not checked. Re-writing a column overwrites it.
//  Swap:
//   - frame_start & swap_pending: front_sel toggles, swap_pending=0, shown_valid=1,
//     frame_count+1, all on the same edge.
//   - frame_start & ~swap_pending: no change; old front frame is shown again.
//   - final-column transfer in the same cycle as frame_start: the write completes; the swap
//     waits for the NEXT frame_start.
//  Read side (latency exactly 1 clk from pix_x/pix_y to vga_*, all registered):
//   - priority 1: ~shown_valid, pix_x>=WIDTH, or pix_y>=HEIGHT -> 0,0,0
//   - priority 2: shot & 140<=x<180 & 100<=y<140 -> (15,0,0)
//   - priority 3: y<top -> ceiling (3,3,3)
//   - priority 4: y>=bot -> floor (7,7,7)
//   - otherwise wall palette:
//       1 -> (1,0,9), 2 -> (11,1,4), 4 -> (0,1,0), others -> (1,0,1)  (r,g,b)
//   - front-bank read is asynchronous (distributed RAM) so total latency stays 1.
//  Reset mid-frame: partially written back bank abandoned. The next frame is refilled from
//   column 0 by the caster; nothing is shown until the first swap.
// STRUCTURE
//  - doom_pkg: WIDTH, HEIGHT, CEIL_RGB, FLOOR_RGB, palette table, flash window bounds,
//    column-entry field offsets.
//  - Sub-module column_bank: WIDTH x 20 RAM with one sync write port and one async read port.
//    Instantiate two; front_sel steers write-enable and the read mux.
// TESTING
//  - Reset, then write cols 0..319 with h=100, colour 1, then a frame_start pulse:
//    swap_pending 1 -> 0, frame_count=1; pixel (5,70)=(1,0,9), (5,69)=(3,3,3), (5,170)=(7,7,7).
//  - wr_height=255 at col 7: top=0, bot=240; every y<240 at x=7 shows the wall colour.
//  - After a full frame: wr_ready=0 until frame_start; a wr_valid held 20 cycles is not
//    accepted and the front bank is unchanged.
//  - Final-column write on the frame_start cycle: no swap then; swap on the next pulse
//    with frame_count+1.
//  - shot=1 at (150,120) -> (15,0,0); shot=0 -> wall/ceiling colour. (400,10) and (10,300) -> 0.
//  - Assert rst mid-frame (col 150): outputs 0 immediately. Then a full refill plus
//    frame_start shows the new data with frame_count=1.

Source files
------------

// File: rtl/column_frame_buffer_pkg.sv
// Shared constants and types for the column frame buffer.
// Contents: screen geometry, column-entry layout, fixed scene colours,
// muzzle-flash window bounds and the wall palette lookup.
package column_frame_buffer_pkg;

    localparam int unsigned WIDTH  = 320;  // columns per frame
    localparam int unsigned HEIGHT = 240;  // rows per frame, must stay below 256
    localparam int unsigned COL_W  = 9;    // column index width

    // Column entry: field order fixes the bit offsets {bot[19:12], top[11:4], color[3:0]}.
    typedef struct packed {
        logic [7:0] bot;    // first floor row (exclusive end of the wall)
        logic [7:0] top;    // first wall row
        logic [3:0] color;  // wall colour code
    } col_entry_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t BLACK_RGB = '{r: 4'd0,  g: 4'd0, b: 4'd0};
    localparam rgb_t CEIL_RGB  = '{r: 4'd3,  g: 4'd3, b: 4'd3};
    localparam rgb_t FLOOR_RGB = '{r: 4'd7,  g: 4'd7, b: 4'd7};
    localparam rgb_t FLASH_RGB = '{r: 4'd15, g: 4'd0, b: 4'd0};

    // Muzzle-flash window, half-open intervals [LO, HI).
    localparam int unsigned FLASH_X_LO = 140;
    localparam int unsigned FLASH_X_HI = 180;
    localparam int unsigned FLASH_Y_LO = 100;
    localparam int unsigned FLASH_Y_HI = 140;

    function automatic rgb_t wall_rgb(input logic [3:0] color);
        rgb_t c;
        case (color)
            4'd1:    c = '{r: 4'd1,  g: 4'd0, b: 4'd9};
            4'd2:    c = '{r: 4'd11, g: 4'd1, b: 4'd4};
            4'd4:    c = '{r: 4'd0,  g: 4'd1, b: 4'd0};
            default: c = '{r: 4'd1,  g: 4'd0, b: 4'd1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/column_frame_buffer_bank.sv
// One column bank: DEPTH x 20-bit store, synchronous write, asynchronous read.
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
// Contents are not reset.
module column_frame_buffer_bank
    import column_frame_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 320,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  col_entry_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output col_entry_t        rdata
);

    col_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Async read keeps the pixel path at a single register stage.
    assign rdata = mem[raddr];

endmodule

// File: rtl/column_frame_buffer.sv
// Double-buffered column store between the ray caster and VGA scan-out.
// Ports:
//   clk, rst                      clock, async active-high reset
//   wr_valid/wr_ready             caster result handshake
//   wr_col/wr_height/wr_color     result payload
//   frame_start                   1-cycle pulse at start of vertical blank
//   pix_x, pix_y, shot            live scan position and muzzle-flash enable
//   vga_r/g/b                     registered colour, 1 clk after pix_x/pix_y
//   swap_pending                  back bank complete, waiting for frame_start
//   frame_count                   number of bank swaps (wraps)
module column_frame_buffer
    import column_frame_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [COL_W-1:0] wr_col,
    input  logic [7:0]       wr_height,
    input  logic [3:0]       wr_color,
    input  logic             frame_start,
    input  logic [9:0]       pix_x,
    input  logic [8:0]       pix_y,
    input  logic             shot,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             swap_pending,
    output logic [12:0]      frame_count
);

    logic       front_sel_q;    // bank currently scanned out
    logic       shown_valid_q;  // at least one swap since reset
    logic [7:0] h_clip;
    logic [7:0] wall_top;
    logic       wr_hit;
    logic       we0;
    logic       we1;
    col_entry_t wr_entry;
    col_entry_t rd0;
    col_entry_t rd1;
    col_entry_t front_entry;
    logic       x_in;
    logic       y_in;
    logic       in_flash;
    rgb_t       rgb_d;

    assign wr_ready = ~swap_pending;

    // Clip to screen height and centre the wall vertically.
    assign h_clip   = (wr_height > 8'(HEIGHT)) ? 8'(HEIGHT) : wr_height;
    assign wall_top = (8'(HEIGHT) - h_clip) >> 1;
    assign wr_entry = '{bot: wall_top + h_clip, top: wall_top, color: wr_color};

    // Out-of-range columns are handshaken but dropped.
    assign wr_hit = wr_valid & wr_ready & (wr_col < COL_W'(WIDTH));
    assign we0    = wr_hit & front_sel_q;
    assign we1    = wr_hit & ~front_sel_q;

    column_frame_buffer_bank #(
        .DEPTH  (WIDTH),
        .ADDR_W (COL_W)
    ) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (wr_col),
        .wdata (wr_entry),
        .raddr (pix_x[COL_W-1:0]),
        .rdata (rd0)
    );

    column_frame_buffer_bank #(
        .DEPTH  (WIDTH),
        .ADDR_W (COL_W)
    ) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (wr_col),
        .wdata (wr_entry),
        .raddr (pix_x[COL_W-1:0]),
        .rdata (rd1)
    );

    assign front_entry = front_sel_q ? rd1 : rd0;

    assign x_in     = pix_x < 10'(WIDTH);
    assign y_in     = pix_y < 9'(HEIGHT);
    assign in_flash = (pix_x >= 10'(FLASH_X_LO)) && (pix_x < 10'(FLASH_X_HI)) &&
                      (pix_y >= 9'(FLASH_Y_LO)) && (pix_y < 9'(FLASH_Y_HI));

    always_comb begin
        rgb_d = BLACK_RGB;
        if (!shown_valid_q || !x_in || !y_in) begin
            rgb_d = BLACK_RGB;
        end else if (shot && in_flash) begin
            rgb_d = FLASH_RGB;
        end else if (pix_y < {1'b0, front_entry.top}) begin
            rgb_d = CEIL_RGB;
        end else if (pix_y >= {1'b0, front_entry.bot}) begin
            rgb_d = FLOOR_RGB;
        end else begin
            rgb_d = wall_rgb(front_entry.color);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r         <= 4'd0;
            vga_g         <= 4'd0;
            vga_b         <= 4'd0;
            swap_pending  <= 1'b0;
            frame_count   <= 13'd0;
            front_sel_q   <= 1'b0;
            shown_valid_q <= 1'b0;
        end else begin
            vga_r <= rgb_d.r;
            vga_g <= rgb_d.g;
            vga_b <= rgb_d.b;
            // A swap blocks writes (wr_ready low), so the two branches never collide.
            // A final-column write coinciding with frame_start only arms the next swap.
            if (frame_start && swap_pending) begin
                front_sel_q   <= ~front_sel_q;
                swap_pending  <= 1'b0;
                shown_valid_q <= 1'b1;
                frame_count   <= frame_count + 13'd1;
            end else if (wr_hit && (wr_col == COL_W'(WIDTH - 1))) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_column_frame_buffer.sv
// Self-checking bench for column_frame_buffer: hand-derived vector table plus
// randomized frames checked against a frame-level model (whole-frame copy on swap).
module tb_column_frame_buffer;

    localparam int W = 320;
    localparam int H = 240;

    typedef struct {
        int top;
        int bot;
        int color;
    } ent_t;

    typedef struct {
        int x;
        int y;
        bit s;
        int exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [8:0]  wr_col;
    logic [7:0]  wr_height;
    logic [3:0]  wr_color;
    logic        frame_start;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        shot;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        swap_pending;
    logic [12:0] frame_count;

    int vectors = 0;
    int miscompares = 0;

    ent_t m_front [W];
    ent_t m_back  [W];
    bit   m_pending;
    bit   m_shown;
    int   m_count;

    vec_t tbl [17];

    column_frame_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_col       (wr_col),
        .wr_height    (wr_height),
        .wr_color     (wr_color),
        .frame_start  (frame_start),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .shot         (shot),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .swap_pending (swap_pending),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic ent_t make_ent(input int h, input int c);
        ent_t e;
        int hh;
        hh = (h > H) ? H : h;
        e.top = (H - hh) / 2;
        e.bot = e.top + hh;
        e.color = c;
        return e;
    endfunction

    function automatic int palette(input int c);
        case (c)
            1:       return 'h109;
            2:       return 'hB14;
            4:       return 'h010;
            default: return 'h101;
        endcase
    endfunction

    function automatic int exp_pixel(input int x, input int y, input bit s);
        ent_t e;
        if (!m_shown || x >= W || y >= H) return 0;
        if (s && x >= 140 && x < 180 && y >= 100 && y < 140) return 'hF00;
        e = m_front[x];
        if (y < e.top) return 'h333;
        if (y >= e.bot) return 'h777;
        return palette(e.color);
    endfunction

    task automatic swap_model();
        m_front = m_back;
        m_pending = 1'b0;
        m_shown = 1'b1;
        m_count = (m_count + 1) % 8192;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int col, input int h, input int c, input bit fs);
        check("wr_ready", {31'd0, wr_ready}, {31'd0, !m_pending});
        wr_valid = 1'b1;
        wr_col = col[8:0];
        wr_height = h[7:0];
        wr_color = c[3:0];
        frame_start = fs;
        @(posedge clk);
        if (fs && m_pending) begin
            swap_model();
        end else if (!m_pending && col < W) begin
            m_back[col] = make_ent(h, c);
            if (col == W - 1) m_pending = 1'b1;
        end
        #1;
        wr_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk);
        if (m_pending) swap_model();
        #1;
        frame_start = 1'b0;
        check("swap_pending", {31'd0, swap_pending}, {31'd0, m_pending});
        check("frame_count", {19'd0, frame_count}, m_count);
    endtask

    task automatic pix_check(input string name, input int x, input int y, input bit s);
        pix_x = x[9:0];
        pix_y = y[8:0];
        shot = s;
        tick();
        check(name, {20'd0, vga_r, vga_g, vga_b}, exp_pixel(x, y, s));
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            pix_check("rand_pix", $urandom_range(0, 340), $urandom_range(0, 260),
                      1'($urandom_range(0, 1)));
        end
    endtask

    // Writes columns 0..last with random stalls and junk out-of-range results.
    task automatic fill(input bit rnd, input int last);
        for (int col = 0; col <= last; col++) begin
            int h;
            int c;
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 15) == 0) begin
                push(W + $urandom_range(0, 191), $urandom_range(0, 255), $urandom_range(0, 15), 1'b0);
            end
            if (rnd) begin
                h = $urandom_range(0, 255);
                c = $urandom_range(0, 15);
                if (col == 7) h = 255;
                if (col == 3) begin
                    h = 100;
                    c = 2;
                end
            end else begin
                h = 100;
                c = 1;
            end
            push(col, h, c, 1'b0);
            if (rnd && col > 10 && $urandom_range(0, 31) == 0) begin
                push($urandom_range(10, col - 1), $urandom_range(0, 255), $urandom_range(0, 15), 1'b0);
            end
        end
    endtask

    initial begin
        // Frame of h=100, colour 1: top=70, bot=170.
        tbl[0]  = '{x: 5,   y: 70,  s: 1'b0, exp: 'h109};
        tbl[1]  = '{x: 5,   y: 69,  s: 1'b0, exp: 'h333};
        tbl[2]  = '{x: 5,   y: 170, s: 1'b0, exp: 'h777};
        tbl[3]  = '{x: 5,   y: 169, s: 1'b0, exp: 'h109};
        tbl[4]  = '{x: 150, y: 120, s: 1'b1, exp: 'hF00};
        tbl[5]  = '{x: 150, y: 120, s: 1'b0, exp: 'h109};
        tbl[6]  = '{x: 139, y: 120, s: 1'b1, exp: 'h109};
        tbl[7]  = '{x: 180, y: 120, s: 1'b1, exp: 'h109};
        tbl[8]  = '{x: 140, y: 100, s: 1'b1, exp: 'hF00};
        tbl[9]  = '{x: 179, y: 139, s: 1'b1, exp: 'hF00};
        tbl[10] = '{x: 150, y: 140, s: 1'b1, exp: 'h109};
        tbl[11] = '{x: 150, y: 99,  s: 1'b1, exp: 'h109};
        tbl[12] = '{x: 400, y: 10,  s: 1'b0, exp: 'h000};
        tbl[13] = '{x: 10,  y: 300, s: 1'b0, exp: 'h000};
        tbl[14] = '{x: 320, y: 100, s: 1'b1, exp: 'h000};
        tbl[15] = '{x: 319, y: 239, s: 1'b0, exp: 'h777};
        tbl[16] = '{x: 0,   y: 0,   s: 1'b0, exp: 'h333};

        rst = 1'b1;
        wr_valid = 1'b0;
        wr_col = '0;
        wr_height = '0;
        wr_color = '0;
        frame_start = 1'b0;
        pix_x = 10'd5;
        pix_y = 9'd100;
        shot = 1'b0;
        m_pending = 1'b0;
        m_shown = 1'b0;
        m_count = 0;

        #12;
        check("rst_vga", {20'd0, vga_r, vga_g, vga_b}, 0);
        check("rst_ready", {31'd0, wr_ready}, 1);
        check("rst_pending", {31'd0, swap_pending}, 0);
        check("rst_count", {19'd0, frame_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        pix_check("noshow_pix", 5, 100, 1'b0);

        // Frame 1: constant walls, then table vectors.
        fill(1'b0, W - 1);
        check("f1_pending", {31'd0, swap_pending}, 1);
        check("f1_ready", {31'd0, wr_ready}, 0);
        pulse_fs();
        for (int i = 0; i < 17; i++) begin
            pix_x = tbl[i].x[9:0];
            pix_y = tbl[i].y[8:0];
            shot = tbl[i].s;
            tick();
            check($sformatf("tbl%0d", i), {20'd0, vga_r, vga_g, vga_b}, tbl[i].exp);
        end

        // Frame 2: random walls; writes blocked while the swap is pending.
        fill(1'b1, W - 1);
        wr_valid = 1'b1;
        wr_col = 9'd3;
        wr_height = 8'd0;
        wr_color = 4'd4;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_ready", {31'd0, wr_ready}, {31'd0, !m_pending});
        end
        wr_valid = 1'b0;
        pix_check("hold_front", 3, 120, 1'b0);
        pulse_fs();
        pix_check("f2_col3", 3, 120, 1'b0);
        for (int y = 0; y < H; y++) pix_check("col7", 7, y, 1'b0);
        rand_pixels(200);

        // Frame 3: last column lands on the frame_start cycle.
        fill(1'b1, W - 2);
        push(W - 1, 50, 4, 1'b1);
        check("late_pending", {31'd0, swap_pending}, {31'd0, m_pending});
        check("late_count", {19'd0, frame_count}, m_count);
        rand_pixels(40);
        pulse_fs();
        rand_pixels(200);

        // Reset in the middle of filling a frame.
        fill(1'b1, 150);
        pix_check("pre_rst_flash", 150, 120, 1'b1);
        #2;
        rst = 1'b1;
        m_pending = 1'b0;
        m_shown = 1'b0;
        m_count = 0;
        #1;
        check("midrst_vga", {20'd0, vga_r, vga_g, vga_b}, 0);
        check("midrst_pending", {31'd0, swap_pending}, 0);
        check("midrst_count", {19'd0, frame_count}, 0);
        check("midrst_ready", {31'd0, wr_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        pix_check("post_rst_pix", 150, 120, 1'b1);
        pulse_fs();
        fill(1'b1, W - 1);
        pulse_fs();
        rand_pixels(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
